// File: rtl/fd_pkg.sv
// fd_pkg: shared FSM states, circle geometry constants and the quick-reject index list.
package fd_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DONE} fd_state_e;
  localparam int FD_RADIUS = 3;
  localparam int FD_RING_LEN = 16;
  localparam int FD_QUICK_LEN = 5;
  // Padded to 8 entries so a 3-bit position can index it directly.
  localparam logic [4:0] FD_QUICK_IDX [8] = '{5'd0, 5'd1, 5'd5, 5'd9, 5'd13, 5'd0, 5'd0, 5'd0};
endpackage

// File: rtl/fd_circle_offset.sv
// fd_circle_offset: circle index to address offset for a radius-3 ring on a LINE_W stride image.
module fd_circle_offset #(
  parameter int LINE_W = 180,
  parameter int ADDR_W = 15
) (
  input  logic [4:0]        i_idx,
  output logic [ADDR_W-1:0] o_offset
);
  localparam int W = LINE_W;
  always_comb begin
    case (i_idx)
      5'd1:    o_offset = ADDR_W'(-3*W);
      5'd2:    o_offset = ADDR_W'(-3*W+1);
      5'd3:    o_offset = ADDR_W'(-2*W+2);
      5'd4:    o_offset = ADDR_W'(-W+3);
      5'd5:    o_offset = ADDR_W'(3);
      5'd6:    o_offset = ADDR_W'(W+3);
      5'd7:    o_offset = ADDR_W'(2*W+2);
      5'd8:    o_offset = ADDR_W'(3*W+1);
      5'd9:    o_offset = ADDR_W'(3*W);
      5'd10:   o_offset = ADDR_W'(3*W-1);
      5'd11:   o_offset = ADDR_W'(2*W-2);
      5'd12:   o_offset = ADDR_W'(W-3);
      5'd13:   o_offset = ADDR_W'(-3);
      5'd14:   o_offset = ADDR_W'(-W-3);
      5'd15:   o_offset = ADDR_W'(-2*W-2);
      5'd16:   o_offset = ADDR_W'(-3*W-1);
      default: o_offset = '0;
    endcase
  end
endmodule

// File: rtl/fd_circle_addr_seq.sv
// fd_circle_addr_seq: issues pixel read addresses around a radius-3 circle (full or quick subset).
// Define FD_BORDER_CHECK_EN to reject centres too close to the image edge.
module fd_circle_addr_seq
  import fd_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int LINE_W = 180,
  parameter int IMG_H  = 120
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       quick,
  input  logic [ADDR_W-1:0]          center_addr,
  input  logic [$clog2(LINE_W)-1:0]  center_x,
  input  logic [$clog2(IMG_H)-1:0]   center_y,
  output logic [ADDR_W-1:0]          rd_addr,
  output logic [4:0]                 rd_idx,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       border_err
);
  fd_state_e         r_state, w_next;
  logic [4:0]        r_pos;
  logic [ADDR_W-1:0] r_center;
  logic              r_quick, r_border;
  logic [4:0]        w_idx;
  logic [ADDR_W-1:0] w_off;
  logic              w_last, w_border;
`ifdef FD_BORDER_CHECK_EN
  assign w_border = int'(center_x) < FD_RADIUS || int'(center_x) > LINE_W-1-FD_RADIUS ||
                    int'(center_y) < FD_RADIUS || int'(center_y) > IMG_H-1-FD_RADIUS;
`else
  logic w_unused_xy;
  assign w_unused_xy = ^{center_x, center_y, IMG_H[0]};
  assign w_border = 1'b0;
`endif
  assign w_idx  = r_quick ? FD_QUICK_IDX[r_pos[2:0]] : r_pos;
  assign w_last = r_quick ? (r_pos == 5'(FD_QUICK_LEN-1)) : (r_pos == 5'(FD_RING_LEN));
  fd_circle_offset #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) u_off (.i_idx(w_idx), .o_offset(w_off));
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  w_next = start ? (w_border ? ST_DONE : ST_ISSUE) : ST_IDLE;
      ST_ISSUE: w_next = (rd_ready && w_last) ? ST_DONE : ST_ISSUE;
      default:  w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_pos    <= '0;
      r_center <= '0;
      r_quick  <= 1'b0;
      r_border <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && start) begin
        r_center <= center_addr;
        r_quick  <= quick;
        r_border <= w_border;
        r_pos    <= '0;
      end else if (r_state == ST_ISSUE && rd_ready) begin
        r_pos <= r_pos + 5'd1;
      end
    end
  end
  assign busy       = r_state == ST_ISSUE;
  assign done       = r_state == ST_DONE;
  assign rd_valid   = busy;
  assign rd_addr    = busy ? r_center + w_off : '0;
  assign rd_idx     = busy ? w_idx : '0;
  assign border_err = done & r_border;
endmodule

// File: tb/tb_fd_circle_addr_seq.sv
// tb_fd_circle_addr_seq: directed checks of the circle address sequencer.
module tb_fd_circle_addr_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        quick = 1'b0;
  logic [14:0] center_addr = '0;
  logic [7:0]  center_x = '0;
  logic [6:0]  center_y = '0;
  logic [14:0] rd_addr;
  logic [4:0]  rd_idx;
  logic        rd_valid;
  logic        rd_ready = 1'b1;
  logic        busy, done, border_err;

  int checks = 0;
  int errors = 0;
  logic [14:0] got_addr [32];
  logic [4:0]  got_idx [32];
  logic [14:0] stall_addr [3];
  int got_n, got_done, n_stall;
  logic got_border, got_busy, got_valid;

  int exp_full [17] = '{5000, 4460, 4461, 4642, 4823, 5003, 5183, 5362, 5541,
                        5540, 5539, 5358, 5177, 4997, 4817, 4638, 4459};
  int exp_qaddr [5] = '{5000, 4460, 5003, 5540, 4997};
  int exp_qidx  [5] = '{0, 1, 5, 9, 13};

  fd_circle_addr_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .quick(quick),
    .center_addr(center_addr), .center_x(center_x), .center_y(center_y),
    .rd_addr(rd_addr), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done), .border_err(border_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge; returns at the first view after the sampling edge (cycle N+1).
  task automatic kick(input logic q, input logic [14:0] a, input logic [7:0] x, input logic [6:0] y);
    start = 1'b1; quick = q; center_addr = a; center_x = x; center_y = y;
    step();
    start = 1'b0;
  endtask

  // Collect handshaken beats until done; view k corresponds to cycle N+k.
  task automatic run(input int stall_idx, input bit hold_start);
    got_n = 0; got_done = -1; n_stall = 0;
    for (int k = 1; k <= 40; k++) begin
      if (done) begin
        got_done = k; got_border = border_err; got_busy = busy; got_valid = rd_valid;
        break;
      end
      if (hold_start) begin
        start = 1'b1; center_addr = 15'd9999; quick = 1'b1;
      end
      if (rd_valid && int'(rd_idx) == stall_idx && n_stall < 3) begin
        rd_ready = 1'b0;
        stall_addr[n_stall] = rd_addr;
        n_stall++;
      end else begin
        rd_ready = 1'b1;
        if (rd_valid && got_n < 32) begin
          got_addr[got_n] = rd_addr; got_idx[got_n] = rd_idx; got_n++;
        end
      end
      step();
    end
    start = 1'b0;
    rd_ready = 1'b1;
  endtask

  task automatic test_reset();
    step(); step();
    checks++;
    if ({rd_valid, busy, done, border_err} !== 4'b0 || rd_addr !== 15'd0 || rd_idx !== 5'd0) begin
      errors++;
      $display("FAIL reset_state valid=%b busy=%b done=%b berr=%b addr=%0d idx=%0d required all 0",
               rd_valid, busy, done, border_err, rd_addr, rd_idx);
    end
    rst_n = 1'b1;
    step(); step();
    checks++;
    if (rd_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle valid=%b done=%b required 0 0", rd_valid, done);
    end
  endtask

  task automatic test_full();
    kick(1'b0, 15'd5000, 8'd140, 7'd27);
    checks++;
    if (busy !== 1'b1 || rd_valid !== 1'b1 || rd_idx !== 5'd0) begin
      errors++;
      $display("FAIL full_first busy=%b valid=%b idx=%0d required 1 1 0", busy, rd_valid, rd_idx);
    end
    run(-1, 1'b0);
    checks++;
    if (got_n != 17) begin errors++; $display("FAIL full_count got %0d required 17", got_n); end
    for (int i = 0; i < 17; i++) begin
      checks++;
      if (got_addr[i] !== 15'(exp_full[i]) || got_idx[i] !== 5'(i)) begin
        errors++;
        $display("FAIL full_beat%0d addr=%0d idx=%0d required addr=%0d idx=%0d",
                 i, got_addr[i], got_idx[i], exp_full[i], i);
      end
    end
    checks++;
    if (got_done != 18 || got_busy !== 1'b0 || got_valid !== 1'b0 || got_border !== 1'b0) begin
      errors++;
      $display("FAIL full_done at=%0d busy=%b valid=%b berr=%b required 18 0 0 0",
               got_done, got_busy, got_valid, got_border);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_done_pulse done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_quick();
    kick(1'b1, 15'd5000, 8'd140, 7'd27);
    run(-1, 1'b0);
    checks++;
    if (got_n != 5) begin errors++; $display("FAIL quick_count got %0d required 5", got_n); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (got_addr[i] !== 15'(exp_qaddr[i]) || got_idx[i] !== 5'(exp_qidx[i])) begin
        errors++;
        $display("FAIL quick_beat%0d addr=%0d idx=%0d required addr=%0d idx=%0d",
                 i, got_addr[i], got_idx[i], exp_qaddr[i], exp_qidx[i]);
      end
    end
    checks++;
    if (got_done != 6) begin errors++; $display("FAIL quick_done at=%0d required 6", got_done); end
    step();
  endtask

  task automatic test_stall();
    kick(1'b0, 15'd5000, 8'd140, 7'd27);
    run(4, 1'b0);
    checks++;
    if (n_stall != 3) begin errors++; $display("FAIL stall_count got %0d required 3", n_stall); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (stall_addr[i] !== 15'd4823) begin
        errors++;
        $display("FAIL stall_hold%0d addr=%0d required 4823", i, stall_addr[i]);
      end
    end
    checks++;
    if (got_n != 17 || got_addr[4] !== 15'd4823 || got_addr[5] !== 15'd5003 || got_idx[5] !== 5'd5) begin
      errors++;
      $display("FAIL stall_seq n=%0d a4=%0d a5=%0d i5=%0d required 17 4823 5003 5",
               got_n, got_addr[4], got_addr[5], got_idx[5]);
    end
    checks++;
    if (got_done != 21) begin errors++; $display("FAIL stall_done at=%0d required 21", got_done); end
    step();
  endtask

  task automatic test_border();
    kick(1'b0, 15'd5000, 8'd2, 7'd27);
`ifdef FD_BORDER_CHECK_EN
    checks++;
    if (done !== 1'b1 || border_err !== 1'b1 || rd_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL border_reject done=%b berr=%b valid=%b busy=%b required 1 1 0 0",
               done, border_err, rd_valid, busy);
    end
    step();
    checks++;
    if (done !== 1'b0 || border_err !== 1'b0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL border_after done=%b berr=%b valid=%b required 0 0 0", done, border_err, rd_valid);
    end
`else
    run(-1, 1'b0);
    checks++;
    if (got_n != 17 || got_done != 18 || got_border !== 1'b0) begin
      errors++;
      $display("FAIL border_nocheck beats=%0d done_at=%0d berr=%b required 17 18 0",
               got_n, got_done, got_border);
    end
    step();
`endif
  endtask

  task automatic test_wrap();
    kick(1'b0, 15'd100, 8'd140, 7'd27);
    run(-1, 1'b0);
    checks++;
    if (got_addr[0] !== 15'd100 || got_addr[1] !== 15'd32328) begin
      errors++;
      $display("FAIL wrap a0=%0d a1=%0d required 100 32328", got_addr[0], got_addr[1]);
    end
    checks++;
    if (got_n != 17 || got_done != 18 || got_border !== 1'b0) begin
      errors++;
      $display("FAIL wrap_done beats=%0d at=%0d berr=%b required 17 18 0", got_n, got_done, got_border);
    end
    step();
  endtask

  task automatic test_back_to_back();
    kick(1'b0, 15'd5000, 8'd140, 7'd27);
    run(-1, 1'b1);
    checks++;
    if (got_n != 17 || got_addr[16] !== 15'd4459 || got_addr[9] !== 15'd5540 || got_done != 18) begin
      errors++;
      $display("FAIL ignore_start beats=%0d a9=%0d a16=%0d done_at=%0d required 17 5540 4459 18",
               got_n, got_addr[9], got_addr[16], got_done);
    end
    step();
    checks++;
    if (busy !== 1'b0 || rd_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start_idle busy=%b valid=%b done=%b required 0 0 0", busy, rd_valid, done);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    kick(1'b0, 15'd5000, 8'd140, 7'd27);
    k = 0;
    while (rd_idx !== 5'd7 && k < 30) begin step(); k++; end
    checks++;
    if (rd_idx !== 5'd7 || rd_addr !== 15'd5362) begin
      errors++;
      $display("FAIL mid_reach idx=%0d addr=%0d required 7 5362", rd_idx, rd_addr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rd_valid, busy, done, border_err} !== 4'b0 || rd_addr !== 15'd0 || rd_idx !== 5'd0) begin
      errors++;
      $display("FAIL mid_reset valid=%b busy=%b done=%b berr=%b addr=%0d idx=%0d required all 0",
               rd_valid, busy, done, border_err, rd_addr, rd_idx);
    end
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (rd_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_quiet%0d valid=%b done=%b busy=%b required 0 0 0", i, rd_valid, done, busy);
      end
    end
    kick(1'b1, 15'd5000, 8'd140, 7'd27);
    checks++;
    if (rd_valid !== 1'b1 || rd_idx !== 5'd0 || rd_addr !== 15'd5000) begin
      errors++;
      $display("FAIL mid_restart valid=%b idx=%0d addr=%0d required 1 0 5000", rd_valid, rd_idx, rd_addr);
    end
    run(-1, 1'b0);
    checks++;
    if (got_n != 5 || got_done != 6 || got_addr[4] !== 15'd4997) begin
      errors++;
      $display("FAIL mid_restart_done beats=%0d at=%0d a4=%0d required 5 6 4997", got_n, got_done, got_addr[4]);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_full();
    test_quick();
    test_stall();
    test_border();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fd_circle_addr_seq.md
FD_CIRCLE_ADDR_SEQ -- requirements
Module: fd_circle_addr_seq

Interface
REQ-001 SHALL provide parameter ADDR_W, default 15, pixel-memory address width.
REQ-002 SHALL provide parameter LINE_W, default 180, image line stride in pixels.
REQ-003 SHALL provide parameter IMG_H, default 120, image height in lines.
REQ-004 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  request a circle fetch; sampled only in IDLE.
REQ-007 SHALL have port quick  in  1  1 = quick-reject subset, 0 = full circle; latched with start.
REQ-008 SHALL have port center_addr  in  ADDR_W  centre pixel address; latched with start.
REQ-009 SHALL have port center_x  in  $clog2(LINE_W)  centre column; latched with start.
REQ-010 SHALL have port center_y  in  $clog2(IMG_H)  centre line; latched with start.
REQ-011 SHALL have port rd_addr  out  ADDR_W  read address to pixel memory.
REQ-012 SHALL have port rd_idx  out  5  circle index (0 = centre, 1..16 = ring) of rd_addr.
REQ-013 SHALL have port rd_valid  out  1  rd_addr/rd_idx valid.
REQ-014 SHALL have port rd_ready  in  1  memory accepts current beat.
REQ-015 SHALL have port busy  out  1  sequence in progress.
REQ-016 SHALL have port done  out  1  one-cycle completion pulse.
REQ-017 SHALL have port border_err  out  1  centre too close to edge; valid when done=1.

Function
REQ-018 SHALL add offset(idx) to latched centre_addr, modulo 2^ADDR_W: 0:0, 1:-3W, 2:-3W+1, 3:-2W+2, 4:-W+3, 5:+3, 6:W+3, 7:2W+2, 8:3W+1, 9:3W, 10:3W-1, 11:2W-2, 12:W-3, 13:-3, 14:-W-3, 15:-2W-2, 16:-3W-1 (W=LINE_W).
REQ-019 SHALL issue idx order 0..16 (17 beats) when quick=0, and 0,1,5,9,13 (5 beats) when quick=1.
REQ-020 SHALL implement FSM IDLE -> ISSUE -> DONE -> IDLE.
REQ-021 SHALL, on start=1 in IDLE at cycle N, assert busy and rd_valid with idx 0 at N+1.
REQ-022 SHALL hold rd_addr, rd_idx, rd_valid stable until rd_valid&rd_ready; next beat presented the following cycle; one beat per cycle max when rd_ready stays high.
REQ-023 SHALL, one cycle after the last beat's handshake, enter DONE: done=1, busy=0, rd_valid=0, for exactly one cycle.
REQ-024 SHALL ignore start while busy or in DONE; latched operands never change mid-sequence.
REQ-025 SHALL compute address wrap-around silently (no error) when centre_addr+offset overflows/underflows ADDR_W.

Reset
REQ-026 SHALL, on rst_n=0 (any time, including mid-sequence), enter IDLE with rd_valid=0, busy=0, done=0, border_err=0, rd_addr=0, rd_idx=0.
REQ-027 SHALL, after reset release, issue nothing until a new start.

Configuration
REQ-028 SHALL, with FD_BORDER_CHECK_EN defined, flag centre_x<3, centre_x>LINE_W-4, centre_y<3 or centre_y>IMG_H-4: no beats issued, DONE with border_err=1 at N+1.
REQ-029 SHALL, without FD_BORDER_CHECK_EN, tie border_err to 0 and always issue the sequence.

Structure
REQ-030 SHALL place FSM state enum, circle radius (3), ring length (16) and quick-index list in shared package fd_pkg.
REQ-031 SHALL use sub-module fd_circle_offset: combinational idx -> signed offset, parameterised by LINE_W.

Verification
REQ-032 SHALL test W=180, centre 5000 (x=140,y=27), quick=0, rd_ready=1: addrs 5000,4460,4461,4642,4823,5003,5183,5362,5541,5540,5539,5358,5177,4997,4817,4638,4459; done at N+18.
REQ-033 SHALL test same centre, quick=1: addrs 5000,4460,5003,5540,4997; done at N+6.
REQ-034 SHALL test rd_ready low 3 cycles on idx 4: rd_addr 4823 held stable, total latency +3.
REQ-035 SHALL test, with FD_BORDER_CHECK_EN, centre x=2: no rd_valid, done=1 and border_err=1 at N+1; without macro, 17 beats issued.
REQ-036 SHALL test centre_addr 100, quick=0: idx1 address wraps to 32328 (100-540 mod 32768).
REQ-037 SHALL test rst_n low at idx 7, then start again: restart from idx 0, no stray done.
